// File: rtl/gx4000_asic_unlock.sv
// rtl/gx4000_asic_unlock.sv - GX4000/CPC+ ASIC unlock sequence matcher and RMR2 decoder
// Snoops CRTC-select writes for the Plus unlock sequence and gates the ASIC register page.
module gx4000_asic_unlock #(
   parameter int SEQ_LEN   = 17,
   parameter bit RELOCK_EN = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        plus_mode,
   input  logic [15:0] io_addr,
   input  logic [7:0]  io_data,
   input  logic        io_wr,
   output logic        asic_unlocked,
   output logic        asic_page_en,
   output logic [2:0]  rmr2_rom_sel,
   output logic [1:0]  rmr2_map,
   output logic        unlock_pulse,
   output logic        lock_pulse,
   output logic [4:0]  seq_index
);

   localparam logic [4:0] LAST_INDEX = 5'd16;

   function automatic logic [7:0] seq_byte(input logic [4:0] i);
      case (i)
         5'd0:    seq_byte = 8'hFF;
         5'd1:    seq_byte = 8'h00;
         5'd2:    seq_byte = 8'hFF;
         5'd3:    seq_byte = 8'h77;
         5'd4:    seq_byte = 8'hB3;
         5'd5:    seq_byte = 8'h51;
         5'd6:    seq_byte = 8'hA8;
         5'd7:    seq_byte = 8'hD4;
         5'd8:    seq_byte = 8'h62;
         5'd9:    seq_byte = 8'h39;
         5'd10:   seq_byte = 8'h9C;
         5'd11:   seq_byte = 8'h46;
         5'd12:   seq_byte = 8'h2B;
         5'd13:   seq_byte = 8'h15;
         5'd14:   seq_byte = 8'h8A;
         5'd15:   seq_byte = 8'hCD;
         default: seq_byte = 8'hEE;
      endcase
   endfunction

   logic       io_wr_q;
   logic       accept;
   logic       csel_wr;
   logic       ga_wr;
   logic       unlocked_d;
   logic       page_en_d;
   logic       unlock_pulse_d;
   logic       lock_pulse_d;
   logic [2:0] rom_sel_d;
   logic [1:0] map_d;
   logic [4:0] index_d;

   assign accept  = io_wr && !io_wr_q;
   assign csel_wr = accept && (io_addr[15:8] == 8'hBC);
   assign ga_wr   = accept && (io_addr[15:8] == 8'h7F);

   always_comb begin
      unlocked_d     = asic_unlocked;
      rom_sel_d      = rmr2_rom_sel;
      map_d          = rmr2_map;
      index_d        = seq_index;
      unlock_pulse_d = 1'b0;
      lock_pulse_d   = 1'b0;

      if (csel_wr) begin
         if (seq_index == LAST_INDEX) begin
            // A trailing &FF may itself be the first byte of a new attempt
            index_d = (io_data == 8'hFF) ? 5'd1 : 5'd0;
            if (io_data == 8'hEE) begin
               unlocked_d     = 1'b1;
               unlock_pulse_d = !asic_unlocked;
            end else if (RELOCK_EN) begin
               unlocked_d   = 1'b0;
               lock_pulse_d = asic_unlocked;
               rom_sel_d    = 3'd0;
               map_d        = 2'd0;
            end
         end else if (io_data == seq_byte(seq_index)) begin
            index_d = seq_index + 5'd1;
         end else if (io_data == 8'hFF) begin
            index_d = 5'd1;
         end else begin
            index_d = 5'd0;
         end
      end

      if (ga_wr && asic_unlocked && (io_data[7:5] == 3'b101)) begin
         rom_sel_d = io_data[2:0];
         map_d     = io_data[4:3];
      end

      page_en_d = unlocked_d && (map_d == 2'b11);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         io_wr_q       <= 1'b0;
         asic_unlocked <= 1'b0;
         asic_page_en  <= 1'b0;
         rmr2_rom_sel  <= 3'd0;
         rmr2_map      <= 2'd0;
         unlock_pulse  <= 1'b0;
         lock_pulse    <= 1'b0;
         seq_index     <= 5'd0;
      end else begin
         // Edge tracking runs even when Plus features are disabled
         io_wr_q <= io_wr;
         if (!plus_mode) begin
            asic_unlocked <= 1'b0;
            asic_page_en  <= 1'b0;
            rmr2_rom_sel  <= 3'd0;
            rmr2_map      <= 2'd0;
            unlock_pulse  <= 1'b0;
            lock_pulse    <= 1'b0;
            seq_index     <= 5'd0;
         end else begin
            asic_unlocked <= unlocked_d;
            asic_page_en  <= page_en_d;
            rmr2_rom_sel  <= rom_sel_d;
            rmr2_map      <= map_d;
            unlock_pulse  <= unlock_pulse_d;
            lock_pulse    <= lock_pulse_d;
            seq_index     <= index_d;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset) begin
         assert (int'(seq_index) < SEQ_LEN);
         assert (!(unlock_pulse && lock_pulse));
      end
   end

endmodule

// File: doc/gx4000_asic_unlock.md
Name: gx4000_asic_unlock

Overview:
- Upstream front-end for the GX4000/CPC+ ASIC register page.
- Snoops CPU I/O writes to the CRTC select port (&BCxx) and matches the 17-byte Plus unlock sequence to drive asic_unlocked.
- Decodes RMR2 writes to the Gate Array port (&7Fxx) and drives asic_page_en, which gates the &4000-&7FFF ASIC RAM window used by the downstream ASIC register/RAM block.

Parameters:
- SEQ_LEN, 17, number of bytes in the unlock sequence (fixed table; parameter exists for assertions only).
- RELOCK_EN, 1, when 1 a full sequence ending in a non-&EE byte re-locks the ASIC; when 0 the ASIC stays unlocked until reset.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- plus_mode  in  1  Plus features enable; 0 forces locked/idle
- io_addr  in  16  CPU I/O address
- io_data  in  8  CPU I/O write data
- io_wr  in  1  CPU I/O write strobe, level, may stay high several cycles
- asic_unlocked  out  1  ASIC unlocked flag
- asic_page_en  out  1  ASIC register page mapped at &4000-&7FFF
- rmr2_rom_sel  out  3  RMR2 bits 2:0, lower ROM bank select
- rmr2_map  out  2  RMR2 bits 4:3, lower ROM/ASIC mapping
- unlock_pulse  out  1  one-cycle pulse on the unlock transition
- lock_pulse  out  1  one-cycle pulse on the relock transition
- seq_index  out  5  current match position 0..16 (debug)

Behaviour:
- Reset values: all outputs 0; internal io_wr_q = 0.
- Write acceptance: a write is accepted in the cycle where io_wr=1 and io_wr_q=0 (rising edge). Exactly one accept per strobe. All outputs are registered and update on the clock edge ending the accept cycle (1-cycle latency).
- Port decode:
  - CRTC select write (CSEL): io_addr[15:8]==&BC.
  - Gate Array write (GA): io_addr[15:8]==&7F.
  - All other writes are ignored.
- Sequence table, index 0..16: FF,00,FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD,EE.
- Matcher, on a CSEL accept with index i<16:
  - data==SEQ[i]: index <= i+1.
  - else if data==&FF: index <= 1 (resync on first byte).
  - else: index <= 0.
- Matcher, on a CSEL accept with index==16:
  - data==&EE: asic_unlocked <= 1; unlock_pulse=1 only if previously locked; index <= 0.
  - data!=&EE and RELOCK_EN=1: asic_unlocked <= 0, lock_pulse=1 only if previously unlocked, index <= 0.
  - data!=&EE and RELOCK_EN=0: index <= 0, lock state unchanged.
  - Special case: data==&FF at index 16 (non-&EE path) sets index <= 1, not 0.
- Sequence position: the matcher runs in both locked and unlocked states. GA writes between CSEL bytes neither advance nor reset the index.
- RMR2 (GA accept, asic_unlocked==1, io_data[7:5]==3'b101): rmr2_rom_sel <= io_data[2:0], rmr2_map <= io_data[4:3].
  - RMR2-pattern writes while locked are ignored.
  - Other GA data values (pen/ink/RMR) are ignored.
- asic_page_en = asic_unlocked && rmr2_map==2'b11, registered. It drops in the same cycle asic_unlocked drops.
- On relock: rmr2_rom_sel and rmr2_map are cleared to 0.
- plus_mode==0: synchronously force the reset state every cycle. Accepts are ignored. Edge tracking continues, so a strobe already high when plus_mode rises is not accepted.
- Reset mid-sequence: index returns to 0; a partial sequence is never resumed.
- Pulses: unlock_pulse and lock_pulse are mutually exclusive and never asserted at the same time.

Test Plan:
- Write FF,00,FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD,EE to &BC00 -> asic_unlocked=1 and unlock_pulse=1 for one cycle, both 1 cycle after the &EE accept; seq_index=0.
- Same sequence with byte 5 = &00 -> index resets to 0 at the bad byte; asic_unlocked stays 0. Then &FF -> index=1.
- Unlocked; write &B8 to &7F00 -> rmr2_map=11, asic_page_en=1. Write &A0 -> asic_page_en=0, rmr2_rom_sel=0.
- Locked; write &B8 to &7F00 -> rmr2_map stays 0, asic_page_en=0.
- Unlocked with page_en=1; full sequence ending &A5 (RELOCK_EN=1) -> asic_unlocked=0, asic_page_en=0, lock_pulse=1, rmr2 fields=0.
- io_wr held high 5 cycles with &FF on &BC00 -> exactly one accept (index=1). Assert reset at index 9 -> index=0 and all outputs 0 next cycle.
